// File: rtl/instr_prefetch_queue_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : instr_prefetch_queue_pkg
// Brief   : Shared constants, FSM encoding and sizing helper for the prefetch queue.
// Revision: 1.0
// ----------------------------------------------------------------------------
package instr_prefetch_queue_pkg;

  // Bubble presented to decode when the queue is empty (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : prefetch_fifo
// Brief   : DEPTH-entry synchronous FIFO, flush-dominant, combinational head.
// Revision: 1.0
// ----------------------------------------------------------------------------
module prefetch_fifo
  import instr_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_empty,
  output logic [occ_w(DEPTH)-1:0]  o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = occ_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_wr;
  logic             w_rd;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_wr    = i_push && !w_full && !i_flush;
  assign w_rd    = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_prefetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : instr_prefetch_queue
// Brief   : Sequential instruction prefetcher with credit-based FIFO and branch
//           redirect. Optional perf counters enabled by `define PREFETCH_PERF_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_ack,
  input  logic [INSTR_W-1:0]       imem_rdata,
  input  logic                     isBranchTaken,
  input  logic [ADDR_W-1:0]        branchPC,
  input  logic                     stall,
  output logic                     validF,
  output logic [INSTR_W-1:0]       instructionF,
  output logic [ADDR_W-1:0]        PCF,
  output logic [occ_w(DEPTH)-1:0]  count
`ifdef PREFETCH_PERF_EN
  ,
  output logic [15:0]              perf_drop_cnt,
  output logic [15:0]              perf_empty_cnt
`endif
);

  localparam int CNT_W   = occ_w(DEPTH);
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  fetch_state_t       r_state;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_target_pc;
  logic               w_flush;
  logic               w_ack_busy;
  logic               w_ack_drop;
  logic               w_push;
  logic               w_pop;
  logic               w_credit;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count_next;
  logic [ENTRY_W-1:0] w_head;

  assign w_flush      = isBranchTaken;
  assign w_ack_busy   = imem_ack && (r_state == ST_BUSY);
  assign w_ack_drop   = imem_ack && (r_state == ST_DROP);
  assign w_push       = w_ack_busy && !w_flush;
  assign w_pop        = validF && !stall && !w_flush;
  assign w_count_next = count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_credit     = (w_count_next < CNT_W'(DEPTH));

  assign imem_req  = (r_state == ST_BUSY) || (r_state == ST_DROP);
  assign imem_addr = r_fetch_pc;

  // r_fetch_pc is the address on the bus; during DROP the redirect target
  // waits in r_target_pc so the outstanding address stays stable until ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_target_pc <= RESET_PC;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_flush) begin
            r_state    <= ST_BUSY;
            r_fetch_pc <= branchPC;
          end else if (w_credit) begin
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_flush) begin
            if (w_ack_busy) begin
              r_fetch_pc <= branchPC;
            end else begin
              r_state     <= ST_DROP;
              r_target_pc <= branchPC;
            end
          end else if (w_ack_busy) begin
            r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
            r_state    <= w_credit ? ST_BUSY : ST_IDLE;
          end
        end
        ST_DROP: begin
          if (w_flush) begin
            r_target_pc <= branchPC;
          end else if (w_ack_drop) begin
            r_state    <= ST_BUSY;
            r_fetch_pc <= r_target_pc;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata ({r_fetch_pc, imem_rdata}),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_count (count)
  );

  assign validF       = !w_empty;
  assign instructionF = validF ? w_head[INSTR_W-1:0] : INSTR_W'(NOP_INSTR);
  assign PCF          = validF ? w_head[ENTRY_W-1:INSTR_W] : '0;

`ifdef PREFETCH_PERF_EN
  logic [15:0] r_perf_drop_cnt;
  logic [15:0] r_perf_empty_cnt;
  logic        w_drop_evt;

  // A return is discarded either in DROP or when it coincides with a flush.
  assign w_drop_evt = w_ack_drop || (w_ack_busy && w_flush);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_drop_cnt  <= '0;
      r_perf_empty_cnt <= '0;
    end else begin
      if (w_drop_evt && (r_perf_drop_cnt != 16'hFFFF))
        r_perf_drop_cnt <= r_perf_drop_cnt + 16'd1;
      if (!validF && (r_perf_empty_cnt != 16'hFFFF))
        r_perf_empty_cnt <= r_perf_empty_cnt + 16'd1;
    end
  end

  assign perf_drop_cnt  = r_perf_drop_cnt;
  assign perf_empty_cnt = r_perf_empty_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_instr_prefetch_queue
// Brief   : Self-checking bench for instr_prefetch_queue against a queue-based model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        isBranchTaken = 1'b0;
  logic [31:0] branchPC = '0;
  logic        stall = 1'b0;
  logic        validF;
  logic [31:0] instructionF;
  logic [31:0] PCF;
  logic [2:0]  count;
`ifdef PREFETCH_PERF_EN
  logic [15:0] perf_drop_cnt;
  logic [15:0] perf_empty_cnt;
`endif

  instr_prefetch_queue #(
    .DEPTH    (DEPTH),
    .ADDR_W   (32),
    .INSTR_W  (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .isBranchTaken (isBranchTaken),
    .branchPC      (branchPC),
    .stall         (stall),
    .validF        (validF),
    .instructionF  (instructionF),
    .PCF           (PCF),
    .count         (count)
`ifdef PREFETCH_PERF_EN
    ,
    .perf_drop_cnt  (perf_drop_cnt),
    .perf_empty_cnt (perf_empty_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the instruction stream as a queue plus request bookkeeping.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      m_q[$];
  bit          m_out;
  bit          m_stale;
  logic [31:0] m_pc;
  logic [31:0] m_stale_addr;
  int          m_drops;
  int          m_empty;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_stale ? m_stale_addr : m_pc;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_out        = 1'b0;
    m_stale      = 1'b0;
    m_pc         = RESET_PC;
    m_stale_addr = RESET_PC;
    m_drops      = 0;
    m_empty      = 0;
  endtask

  task automatic model_step(input bit st, input bit fl, input logic [31:0] bpc, input bit ack);
    bit ack_eff;
    ack_eff = m_out && ack;
    if (m_q.size() == 0 && m_empty < 65535) m_empty++;
    if (fl) begin
      if (ack_eff && m_drops < 65535) m_drops++;
      m_q.delete();
      if (m_out && !m_stale && !ack) begin
        m_stale      = 1'b1;
        m_stale_addr = m_pc;
      end else if (!m_stale) begin
        m_out = 1'b1;
      end
      m_pc = bpc;
    end else begin
      if (m_q.size() > 0 && !st) void'(m_q.pop_front());
      if (ack_eff) begin
        if (m_stale) begin
          m_stale = 1'b0;
          if (m_drops < 65535) m_drops++;
        end else begin
          m_q.push_back('{pc: m_pc, instr: mem_data(m_pc)});
          m_pc  = m_pc + 32'd4;
          m_out = (m_q.size() < DEPTH);
        end
      end else if (!m_out) begin
        m_out = (m_q.size() < DEPTH);
      end
    end
  endtask

  task automatic compare_all();
    bit v;
    v = (m_q.size() > 0);
    check_eq("validF", validF, v);
    if (v) begin
      check_eq("PCF", PCF, m_q[0].pc);
      check_eq("instructionF", instructionF, m_q[0].instr);
    end else begin
      check_eq("PCF_empty", PCF, 32'h0);
      check_eq("instructionF_empty", instructionF, NOP);
    end
    check_eq("count", count, m_q.size());
    check_eq("imem_req", imem_req, m_out);
    check_eq("imem_addr", imem_addr, exp_addr());
`ifdef PREFETCH_PERF_EN
    check_eq("perf_drop_cnt", perf_drop_cnt, m_drops);
    check_eq("perf_empty_cnt", perf_empty_cnt, m_empty);
`endif
  endtask

  // Called 1 ns after a rising edge; returns 1 ns after the next one.
  task automatic cycle(input bit st, input bit fl, input logic [31:0] bpc, input bit ack);
    stall         = st;
    isBranchTaken = fl;
    branchPC      = bpc;
    imem_ack      = ack;
    imem_rdata    = mem_data(exp_addr());
    @(posedge clk);
    #1;
    model_step(st, fl, bpc, ack);
    compare_all();
  endtask

  task automatic do_reset();
    #2;
    reset         = 1'b0;
    imem_ack      = 1'b0;
    isBranchTaken = 1'b0;
    stall         = 1'b0;
    #1;
    check_eq("rst_imem_req", imem_req, 0);
    check_eq("rst_validF", validF, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_PCF", PCF, 0);
    check_eq("rst_instr", instructionF, NOP);
    check_eq("rst_addr", imem_addr, RESET_PC);
`ifdef PREFETCH_PERF_EN
    check_eq("rst_perf_drop", perf_drop_cnt, 0);
    check_eq("rst_perf_empty", perf_empty_cnt, 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic run_random(input int n, input int lat_max, input int stall_pct, input int flush_pct);
    int          age;
    int          lat;
    bit          st;
    bit          fl;
    bit          ack;
    bit          was_out;
    logic [31:0] bpc;
    age = 0;
    lat = $urandom_range(lat_max, 0);
    for (int i = 0; i < n; i++) begin
      st  = ($urandom_range(99, 0) < stall_pct);
      fl  = ($urandom_range(99, 0) < flush_pct);
      if ($urandom_range(7, 0) == 0) bpc = 32'hFFFF_FFF0 + ($urandom_range(3, 0) * 4);
      else                           bpc = $urandom & 32'hFFFF_FFFC;
      was_out = m_out;
      ack     = m_out ? (age >= lat) : ($urandom_range(9, 0) == 0);
      cycle(st, fl, bpc, ack);
      if (m_out && (!was_out || ack)) begin
        age = 0;
        lat = $urandom_range(lat_max, 0);
      end else begin
        age++;
      end
    end
  endtask

  initial begin
    logic [31:0] pcf_hold;
    reset = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Zero-wait stream: request in cycle 1, PCF 0,4,8,... from cycle 2.
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b0, 1'b0, 32'h0, m_out);
      check_eq("zw_valid", validF, (k >= 2));
      if (k == 1) check_eq("zw_req_c1", imem_req, 1);
      if (k >= 2) check_eq("zw_pcf", PCF, 32'((k - 2) * 4));
    end

    // Decode stall fills the queue and stops fetching.
    pcf_hold = PCF;
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 32'h0, m_out);
    check_eq("stall_count", count, DEPTH);
    check_eq("stall_req", imem_req, 0);
    check_eq("stall_pcf", PCF, pcf_hold);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 32'h0, m_out);

    // Redirect while a slow request is outstanding.
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h100, 1'b0);
    check_eq("drop_req", imem_req, 1);
    check_eq("drop_stale_addr", imem_addr, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("br_count", count, 0);
    check_eq("br_addr", imem_addr, 32'h100);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("br_valid", validF, 1);
    check_eq("br_pcf", PCF, 32'h100);

    // Flush coinciding with ack and pop.
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 32'h0, m_out);
    check_eq("fl_pre_valid", validF, 1);
    cycle(1'b0, 1'b1, 32'h200, 1'b1);
    check_eq("fl_count", count, 0);
    check_eq("fl_valid", validF, 0);
    check_eq("fl_addr", imem_addr, 32'h200);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("fl_redirect_pcf", PCF, 32'h200);

    // Address wrap at the top of the space.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, m_out);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("wrap_addr", imem_addr, 32'h0);
    check_eq("wrap_pcf_top", PCF, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("wrap_pcf_zero", PCF, 32'h0);

    // Reset in the middle of an outstanding request, then a stray ack.
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("midrst_pre_req", imem_req, 1);
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("restart_req", imem_req, 1);
    check_eq("restart_addr", imem_addr, RESET_PC);
    check_eq("restart_count", count, 0);

    // Two flushes against outstanding requests.
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h40, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h80, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("two_drop_addr", imem_addr, 32'h80);
`ifdef PREFETCH_PERF_EN
    check_eq("two_drop_perf", perf_drop_cnt, 2);
`endif

    run_random(800, 0, 30, 5);
    run_random(800, 3, 40, 8);
    run_random(400, 2, 10, 20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
